// File: rtl/cla_mp_adder.sv
// -----------------------------------------------------------------------------
// cla_mp_adder
// Streaming multi-precision add/subtract unit. An operand of LIMBS*WIDTH bits
// arrives one limb per transfer, least-significant limb first. Each limb is
// summed by a two-level carry-lookahead core; the limb carry-out is held in
// c_reg and becomes the next limb's carry-in. Whole-word carry/borrow,
// signed-overflow and zero flags are reported with the most-significant limb.
//
// Parameters
//   WIDTH  limb width in bits (multiple of GROUP)
//   LIMBS  limbs per operand (>= 1)
//   GROUP  bits per lookahead group
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input limb handshake
//   in_a, in_b           operand limbs
//   in_sub, in_cin       mode and carry/borrow-in, sampled on limb 0 only
//   out_valid/out_ready  result limb handshake
//   out_sum, out_last    result limb, most-significant-limb marker
//   out_cout/ovf/zero    whole-word flags, valid with out_last, 0 otherwise
//   busy                 an operand is partially received
// -----------------------------------------------------------------------------
module cla_mp_adder #(
  parameter int WIDTH = 8,
  parameter int LIMBS = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int NG    = WIDTH / GROUP;
  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_reg;
  logic             mode_q;
  logic             z_reg;

  logic             xfer;
  logic             first;
  logic             mode;
  logic             c_in;
  logic             is_last;
  logic             z_next;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  // Lookahead core signals
  logic [WIDTH-1:0] g, p;
  logic [NG-1:0]    gg, gp;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic             acc, prop;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q == RUN);
  assign first    = (state_q == IDLE);

  // Limb 0 takes mode and carry from the ports; later limbs use the latched
  // mode and the carry chained from the previous limb. Subtraction is
  // A + ~B + 1 with borrow-in folded into the carry as ~cin.
  assign mode    = first ? in_sub : mode_q;
  assign c_in    = first ? (in_cin ^ in_sub) : c_reg;
  assign b_eff   = in_b ^ {WIDTH{mode}};
  assign is_last = (LIMBS == 1) || ((state_q == RUN) && (idx_q == LAST_IDX));
  assign z_next  = (first | z_reg) & (sum == '0);

  // NOTE: every variable written here gets a default before any loop or branch
  // so that no path can leave one unassigned and infer a latch.
  always_comb begin
    g    = in_a & b_eff;
    p    = in_a ^ b_eff;
    gg   = '0;
    gp   = '1;
    gc   = '0;
    c    = '0;
    acc  = 1'b0;
    prop = 1'b0;

    // Group generate/propagate.
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+j];
      end
    end

    // Second level: each group carry is a flat sum of products over all lower
    // groups and the limb carry-in, so it does not wait on its neighbour.
    gc[0] = c_in;
    for (int k = 0; k < NG; k++) begin
      acc  = gg[k];
      prop = gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prop & gg[j]);
        prop = prop & gp[j];
      end
      gc[k+1] = acc | (prop & c_in);
    end

    // Bit carries inside each group start from the lookahead group carry.
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int j = 1; j < GROUP; j++) begin
        c[k*GROUP+j] = g[k*GROUP+j-1] | (p[k*GROUP+j-1] & c[k*GROUP+j-1]);
      end
    end
    c[WIDTH] = gc[NG];
  end

  assign sum   = p ^ c[WIDTH-1:0];
  assign c_out = c[WIDTH];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      c_reg     <= 1'b0;
      mode_q    <= 1'b0;
      z_reg     <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (xfer) begin
      c_reg     <= c_out;
      z_reg     <= z_next;
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_last  <= is_last;
      // Borrow-out is the inverted raw carry when subtracting.
      out_cout  <= is_last & (c_out ^ mode);
      out_ovf   <= is_last & (c[WIDTH-1] ^ c_out);
      out_zero  <= is_last & z_next;
      if (first) mode_q <= in_sub;
      case (state_q)
        IDLE: begin
          if (LIMBS > 1) begin
            state_q <= RUN;
            idx_q   <= IDX_W'(1);
          end
        end
        RUN: begin
          if (is_last) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_mp_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_mp_adder
// Two instances: dut_a (WIDTH=8, LIMBS=4, GROUP=4) and dut_b (WIDTH=16,
// LIMBS=1, GROUP=4). Expected results come from a whole-word arithmetic model
// using 64-bit integers; result beats are collected by negedge monitors.
// -----------------------------------------------------------------------------
module tb_cla_mp_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_in_sub, a_in_cin;
  logic [7:0]  a_in_a, a_in_b, a_out_sum;
  logic        a_out_valid, a_out_ready, a_out_last, a_out_cout, a_out_ovf, a_out_zero, a_busy;

  logic        b_in_valid, b_in_ready, b_in_sub, b_in_cin;
  logic [15:0] b_in_a, b_in_b, b_out_sum;
  logic        b_out_valid, b_out_ready, b_out_last, b_out_cout, b_out_ovf, b_out_zero, b_busy;

  cla_mp_adder #(.WIDTH(8), .LIMBS(4), .GROUP(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_sub(a_in_sub), .in_cin(a_in_cin),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_last(a_out_last), .out_cout(a_out_cout),
    .out_ovf(a_out_ovf), .out_zero(a_out_zero), .busy(a_busy)
  );

  cla_mp_adder #(.WIDTH(16), .LIMBS(1), .GROUP(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_sub(b_in_sub), .in_cin(b_in_cin),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_last(b_out_last), .out_cout(b_out_cout),
    .out_ovf(b_out_ovf), .out_zero(b_out_zero), .busy(b_busy)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
    logic        zero;
  } beat_t;

  typedef struct {
    longint unsigned sum;
    bit              cout;
    bit              ovf;
    bit              zero;
  } model_t;

  beat_t got_a[$];
  beat_t got_b[$];
  int    checks = 0;
  int    errors = 0;
  bit    rand_bp = 1'b0;

  // Monitors: a beat is consumed when out_valid && out_ready at the coming edge.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready)
      got_a.push_back(beat_t'({8'h00, a_out_sum, a_out_last, a_out_cout, a_out_ovf, a_out_zero}));
    if (!rst && b_out_valid && b_out_ready)
      got_b.push_back(beat_t'({b_out_sum, b_out_last, b_out_cout, b_out_ovf, b_out_zero}));
  end

  // Random downstream backpressure on dut_a, enabled by rand_bp.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      a_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Whole-word reference: n-bit unsigned/signed arithmetic on 64-bit integers.
  function automatic model_t model(input longint unsigned a, input longint unsigned b,
                                   input bit sub, input bit cin, input int n);
    model_t m;
    longint unsigned md;
    longint sa, sb, r, half;
    md   = 64'd1 << n;
    half = longint'(md >> 1);
    sa   = (a >= md / 2) ? longint'(a) - longint'(md) : longint'(a);
    sb   = (b >= md / 2) ? longint'(b) - longint'(md) : longint'(b);
    if (sub) begin
      m.sum  = (a - b - longint'(cin)) % md;
      m.cout = (a < b + longint'(cin));
      r      = sa - sb - longint'(cin);
    end else begin
      m.sum  = (a + b + longint'(cin)) % md;
      m.cout = ((a + b + longint'(cin)) >= md);
      r      = sa + sb + longint'(cin);
    end
    m.ovf  = (r >= half) || (r < -half);
    m.zero = (m.sum == 0);
    return m;
  endfunction

  // Expected beat i of a word modelled as m, for limb width w and limb count.
  function automatic beat_t exp_beat(input model_t m, input int i, input int w, input int limbs);
    beat_t e;
    bit    last;
    last   = (i == limbs - 1);
    e.sum  = 16'((m.sum >> (w * i)) & ((64'd1 << w) - 1));
    e.last = last;
    e.cout = last & m.cout;
    e.ovf  = last & m.ovf;
    e.zero = last & m.zero;
    return e;
  endfunction

  // Drivers assume they start between a rising edge and the next falling edge.
  task automatic drive_a(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
    bit ok = 1'b0;
    a_in_valid = 1'b1; a_in_a = a; a_in_b = b; a_in_sub = sub; a_in_cin = cin;
    for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drive_a timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic drive_b(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
    bit ok = 1'b0;
    b_in_valid = 1'b1; b_in_a = a; b_in_b = b; b_in_sub = sub; b_in_cin = cin;
    for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drive_b timeout: in_ready stayed 0, required 1");
    end
  endtask

  // Sends one 32-bit operand; with junk set, limbs 1..3 carry random sub/cin.
  task automatic send_word_a(input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic cin, input bit junk);
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || !junk) drive_a(a[8*i +: 8], b[8*i +: 8], sub, cin);
      else drive_a(a[8*i +: 8], b[8*i +: 8], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_a(input int n);
    for (int c = 0; c < n * 10 + 50 && got_a.size() < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_b(input int n);
    for (int c = 0; c < n * 2 + 50 && got_b.size() < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_sub = 0; a_in_cin = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_sub = 0; b_in_cin = 0; b_out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_sum, a_out_last, a_out_cout, a_out_ovf, a_out_zero, a_busy, a_in_ready}
        !== {1'b0, 8'h00, 5'b00000, 1'b1}) begin
      errors++;
      $display("FAIL reset_a: got v=%b sum=%h l=%b c=%b o=%b z=%b busy=%b rdy=%b, required all 0 and rdy=1",
               a_out_valid, a_out_sum, a_out_last, a_out_cout, a_out_ovf, a_out_zero, a_busy, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_out_sum, b_busy, b_in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_b: got v=%b sum=%h busy=%b rdy=%b, required 0 0000 0 1",
               b_out_valid, b_out_sum, b_busy, b_in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] va[2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    model_t m;
    beat_t  e;
    for (int v = 0; v < 2; v++) begin
      m = model(va[v], 32'h1, 1'b0, 1'b0, 32);
      got_a.delete();
      send_word_a(va[v], 32'h1, 1'b0, 1'b0, 1'b0);
      wait_a(4);
      checks++;
      if (got_a.size() != 4) begin
        errors++;
        $display("FAIL add%0d beat count: got %0d, required 4", v, got_a.size());
      end
      for (int i = 0; i < 4 && i < got_a.size(); i++) begin
        e = exp_beat(m, i, 8, 4);
        checks++;
        if (got_a[i] !== e) begin
          errors++;
          $display("FAIL add%0d beat %0d: got %h, required %h", v, i, got_a[i], e);
        end
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] va[3] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0005};
    logic [31:0] vb[3] = '{32'h0000_0001, 32'h1234_5678, 32'h0000_0003};
    logic        vc[3] = '{1'b0, 1'b0, 1'b1};
    model_t m;
    beat_t  e;
    for (int v = 0; v < 3; v++) begin
      m = model(va[v], vb[v], 1'b1, vc[v], 32);
      got_a.delete();
      send_word_a(va[v], vb[v], 1'b1, vc[v], 1'b0);
      wait_a(4);
      checks++;
      if (got_a.size() != 4) begin
        errors++;
        $display("FAIL sub%0d beat count: got %0d, required 4", v, got_a.size());
      end
      for (int i = 0; i < 4 && i < got_a.size(); i++) begin
        e = exp_beat(m, i, 8, 4);
        checks++;
        if (got_a[i] !== e) begin
          errors++;
          $display("FAIL sub%0d beat %0d: got %h, required %h", v, i, got_a[i], e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    model_t m;
    beat_t  e, e1;
    a = $urandom; b = $urandom;
    m = model(a, b, 1'b0, 1'b1, 32);
    e1 = exp_beat(m, 1, 8, 4);
    got_a.delete();
    drive_a(a[7:0], b[7:0], 1'b0, 1'b1);
    drive_a(a[15:8], b[15:8], 1'b0, 1'b0);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_a = a[23:16]; a_in_b = b[23:16];
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d in_ready: got %b, required 0", s, a_in_ready);
      end
      checks++;
      if ({a_out_valid, a_out_sum} !== {1'b1, e1.sum[7:0]}) begin
        errors++;
        $display("FAIL stall%0d held output: got v=%b sum=%h, required v=1 sum=%h",
                 s, a_out_valid, a_out_sum, e1.sum[7:0]);
      end
      checks++;
      if (a_busy !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d busy: got %b, required 1", s, a_busy);
      end
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    drive_a(a[23:16], b[23:16], 1'b0, 1'b0);
    drive_a(a[31:24], b[31:24], 1'b0, 1'b0);
    a_in_valid = 1'b0;
    wait_a(4);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 4) begin
      errors++;
      $display("FAIL backpressure beat count: got %0d, required 4", got_a.size());
    end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      e = exp_beat(m, i, 8, 4);
      checks++;
      if (got_a[i] !== e) begin
        errors++;
        $display("FAIL backpressure beat %0d: got %h, required %h", i, got_a[i], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    model_t m;
    beat_t  e;
    drive_a(8'hAA, 8'h77, 1'b0, 1'b1);
    drive_a(8'hFF, 8'h01, 1'b0, 1'b0);
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid state: got v=%b busy=%b rdy=%b, required 0 0 1",
               a_out_valid, a_busy, a_in_ready);
    end
    @(posedge clk);
    #1;
    got_a.delete();
    m = model(32'h2, 32'h3, 1'b0, 1'b0, 32);
    send_word_a(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    wait_a(4);
    checks++;
    if (got_a.size() != 4) begin
      errors++;
      $display("FAIL reset_mid beat count: got %0d, required 4", got_a.size());
    end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      e = exp_beat(m, i, 8, 4);
      checks++;
      if (got_a[i] !== e) begin
        errors++;
        $display("FAIL reset_mid beat %0d: got %h, required %h", i, got_a[i], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    model_t mq[$];
    beat_t  e;
    logic [31:0] a, b;
    logic s, ci;
    got_a.delete();
    rand_bp = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = $urandom; b = $urandom;
      s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      if (k == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; s = 1'b0; ci = 1'b0; end
      if (k == 1) begin a = 32'h8000_0000; b = 32'h0000_0001; s = 1'b1; ci = 1'b0; end
      mq.push_back(model(a, b, s, ci, 32));
      send_word_a(a, b, s, ci, 1'b1);
    end
    wait_a(80);
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    a_out_ready = 1'b1;
    checks++;
    if (got_a.size() != 80) begin
      errors++;
      $display("FAIL b2b beat count: got %0d, required 80", got_a.size());
    end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4 && 4 * k + i < got_a.size(); i++) begin
        e = exp_beat(mq[k], i, 8, 4);
        checks++;
        if (got_a[4*k+i] !== e) begin
          errors++;
          $display("FAIL b2b word %0d beat %0d: got %h, required %h", k, i, got_a[4*k+i], e);
        end
      end
    end
  endtask

  task automatic test_single_limb();
    model_t mq[$];
    beat_t  e;
    logic [15:0] x, y;
    logic s, ci;
    got_b.delete();
    for (int k = 0; k < 1000; k++) begin
      x = 16'($urandom); y = 16'($urandom);
      s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      case (k)
        0: begin x = 16'hFFFF; y = 16'h0001; s = 1'b0; ci = 1'b0; end
        1: begin x = 16'h7FFF; y = 16'h0001; s = 1'b0; ci = 1'b0; end
        2: begin x = 16'h0000; y = 16'h0001; s = 1'b1; ci = 1'b0; end
        3: begin x = 16'h8000; y = 16'h0001; s = 1'b1; ci = 1'b0; end
        4: begin x = 16'h1234; y = 16'h1234; s = 1'b1; ci = 1'b0; end
        default: ;
      endcase
      mq.push_back(model(x, y, s, ci, 16));
      drive_b(x, y, s, ci);
    end
    b_in_valid = 1'b0;
    wait_b(1000);
    checks++;
    if (got_b.size() != 1000) begin
      errors++;
      $display("FAIL single_limb beat count: got %0d, required 1000", got_b.size());
    end
    for (int k = 0; k < 1000 && k < got_b.size(); k++) begin
      e = exp_beat(mq[k], 0, 16, 1);
      checks++;
      if (got_b[k] !== e) begin
        errors++;
        $display("FAIL single_limb pair %0d: got %h, required %h", k, got_b[k], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_single_limb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
